// File: rtl/fb_arbiter.sv
// -----------------------------------------------------------------------------
// fb_arbiter
// Shares one single-port frame-buffer RAM between the VGA scan-out reader
// (display port, fixed priority) and a CPU load/store port. The CPU is
// starvation-guarded: after MAX_WAIT consecutive denied cycles it gets one
// forced slot (BOOST). A display request that collides with a BOOST slot is
// dropped and counted in a saturating miss counter.
//
// Ports
//   clk, clrn                      clock, asynchronous active-low reset
//   disp_req/disp_addr             display read request (single cycle)
//   disp_gnt                       display accepted this cycle (comb.)
//   disp_rvalid/disp_rdata         display read return, 1 cycle after grant
//   cpu_valid/we/addr/wdata        CPU request, held until cpu_ready
//   cpu_ready                      CPU accepted this cycle (comb.)
//   cpu_rvalid/cpu_rdata           CPU read return, 1 cycle after read accept
//   mem_en/we/addr/wdata/rdata     RAM port (rdata has 1-cycle latency)
//   disp_miss_cnt                  saturating count of dropped display reqs
// -----------------------------------------------------------------------------
module fb_arbiter #(
    parameter int AW       = 19,
    parameter int DW       = 24,
    parameter int MAX_WAIT = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             disp_req,
    input  logic [AW-1:0]    disp_addr,
    output logic             disp_gnt,
    output logic             disp_rvalid,
    output logic [DW-1:0]    disp_rdata,
    input  logic             cpu_valid,
    input  logic             cpu_we,
    input  logic [AW-1:0]    cpu_addr,
    input  logic [DW-1:0]    cpu_wdata,
    output logic             cpu_ready,
    output logic             cpu_rvalid,
    output logic [DW-1:0]    cpu_rdata,
    output logic             mem_en,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_wdata,
    input  logic [DW-1:0]    mem_rdata,
    output logic [CNT_W-1:0] disp_miss_cnt
);

    // Wide enough to hold MAX_WAIT itself (the value reached on the boost step).
    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_BOOST  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  miss_q, miss_d;
    logic              disp_rvalid_q, disp_rvalid_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic              disp_gnt_s;
    logic              cpu_ready_s;

    // Arbitration, starvation guard and miss counting for the current cycle.
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        miss_d      = miss_q;
        disp_gnt_s  = 1'b0;
        cpu_ready_s = 1'b0;
        case (state_q)
            ST_NORMAL: begin
                disp_gnt_s  = disp_req;
                cpu_ready_s = cpu_valid & ~disp_req;
                if (cpu_ready_s) begin
                    wait_d = {WAIT_W{1'b0}};
                end else if (cpu_valid) begin
                    // Denied cycle: the MAX_WAIT-th denial arms the forced slot.
                    wait_d = wait_q + WAIT_W'(1);
                    if (wait_q == WAIT_LAST) begin
                        state_d = ST_BOOST;
                    end else begin
                        state_d = ST_NORMAL;
                    end
                end else begin
                    wait_d = wait_q;
                end
            end
            ST_BOOST: begin
                // Display is locked out; a colliding request is lost, not retried.
                cpu_ready_s = cpu_valid;
                state_d     = ST_NORMAL;
                wait_d      = {WAIT_W{1'b0}};
                if (disp_req && (miss_q != CNT_MAX)) begin
                    miss_d = miss_q + CNT_W'(1);
                end else begin
                    miss_d = miss_q;
                end
            end
            default: begin
                state_d = ST_NORMAL;
                wait_d  = {WAIT_W{1'b0}};
            end
        endcase
    end

    // Grants are held off for as long as reset is asserted.
    assign disp_gnt  = disp_gnt_s & clrn;
    assign cpu_ready = cpu_ready_s & clrn;
    assign mem_en    = disp_gnt | cpu_ready;
    assign mem_we    = cpu_ready & cpu_we;
    assign mem_addr  = cpu_ready ? cpu_addr : disp_addr;
    assign mem_wdata = cpu_ready ? cpu_wdata : {DW{1'b0}};

    // Read-return strobes track the grant one cycle later (RAM latency).
    always_comb begin
        disp_rvalid_d = disp_gnt;
        cpu_rvalid_d  = cpu_ready & ~cpu_we;
    end

    // State, wait counter, miss counter and rvalid registers.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q       <= ST_NORMAL;
            wait_q        <= {WAIT_W{1'b0}};
            miss_q        <= {CNT_W{1'b0}};
            disp_rvalid_q <= 1'b0;
            cpu_rvalid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            miss_q        <= miss_d;
            disp_rvalid_q <= disp_rvalid_d;
            cpu_rvalid_q  <= cpu_rvalid_d;
        end
    end

    assign disp_rvalid   = disp_rvalid_q;
    assign cpu_rvalid    = cpu_rvalid_q;
    assign disp_rdata    = mem_rdata;
    assign cpu_rdata     = mem_rdata;
    assign disp_miss_cnt = miss_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fb_arbiter
// Directed bench for fb_arbiter. Instance u_dut uses default parameters and
// is attached to a small behavioural RAM; instance u_sat uses CNT_W=2 and
// MAX_WAIT=1 so the miss counter saturates within a few cycles.
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_fb_arbiter;

    localparam int AW = 19;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          clrn = 1'b0;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic          cpu_valid = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          disp_gnt, disp_rvalid, cpu_ready, cpu_rvalid;
    logic [DW-1:0] disp_rdata, cpu_rdata, mem_wdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic [15:0]   disp_miss_cnt;

    // second instance
    logic          s_req = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_gnt, s_drv, s_ready, s_crv, s_en, s_we;
    logic [DW-1:0] s_drd, s_crd, s_wd;
    logic [AW-1:0] s_ma;
    logic [1:0]    s_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] ram [0:255];

    always #5 clk = ~clk;

    // Behavioural RAM: registered read, 1-cycle latency, write-then-visible.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
            mem_rdata <= ram[mem_addr[7:0]];
        end
    end

    fb_arbiter u_dut (
        .clk(clk), .clrn(clrn),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .cpu_valid(cpu_valid), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid),
        .cpu_rdata(cpu_rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .disp_miss_cnt(disp_miss_cnt)
    );

    fb_arbiter #(.CNT_W(2), .MAX_WAIT(1)) u_sat (
        .clk(clk), .clrn(clrn),
        .disp_req(s_req), .disp_addr(19'h00001), .disp_gnt(s_gnt),
        .disp_rvalid(s_drv), .disp_rdata(s_drd),
        .cpu_valid(s_valid), .cpu_we(1'b0), .cpu_addr(19'h00002),
        .cpu_wdata(24'h000000), .cpu_ready(s_ready), .cpu_rvalid(s_crv),
        .cpu_rdata(s_crd), .mem_en(s_en), .mem_we(s_we),
        .mem_addr(s_ma), .mem_wdata(s_wd), .mem_rdata(24'h000000),
        .disp_miss_cnt(s_cnt)
    );

    task automatic test_reset();
        clrn = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            disp_req  = 1'($urandom_range(0, 1));
            cpu_valid = 1'($urandom_range(0, 1));
            cpu_we    = 1'($urandom_range(0, 1));
            disp_addr = AW'($urandom_range(0, 255));
            cpu_addr  = AW'($urandom_range(0, 255));
            #1;
            n_tests++;
            if ({disp_gnt, cpu_ready, mem_en, mem_we, disp_rvalid, cpu_rvalid} !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_outputs got %b exp 000000",
                         {disp_gnt, cpu_ready, mem_en, mem_we, disp_rvalid, cpu_rvalid});
            end
            n_tests++;
            if (disp_miss_cnt !== 16'd0) begin
                n_fail++;
                $display("FAIL reset_miss got %0d exp 0", disp_miss_cnt);
            end
        end
        @(negedge clk);
        disp_req = 1'b1; cpu_valid = 1'b1; cpu_we = 1'b0;
        disp_addr = 19'h00003; cpu_addr = 19'h00004;
        clrn = 1'b1;
        #1;
        n_tests++;
        if ({disp_gnt, cpu_ready, mem_en} !== 3'b101) begin
            n_fail++;
            $display("FAIL reset_release got %b exp 101", {disp_gnt, cpu_ready, mem_en});
        end
        @(negedge clk);
        disp_req = 1'b0;
        #1;
        // denied once, now granted: clears wait_cnt
        n_tests++;
        if (cpu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_cpu got %b exp 1", cpu_ready);
        end
        @(negedge clk);
        cpu_valid = 1'b0;
    endtask

    task automatic test_cpu_only();
        @(negedge clk);
        cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h00010; cpu_wdata = 24'hABCDEF;
        #1;
        n_tests++;
        if ({cpu_ready, mem_en, mem_we, disp_gnt} !== 4'b1110 || mem_addr !== 19'h00010
            || mem_wdata !== 24'hABCDEF) begin
            n_fail++;
            $display("FAIL cpu_write got rdy/en/we/dg=%b addr=%h wd=%h exp 1110 00010 abcdef",
                     {cpu_ready, mem_en, mem_we, disp_gnt}, mem_addr, mem_wdata);
        end
        @(negedge clk);
        cpu_we = 1'b0;
        #1;
        n_tests++;
        if (cpu_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL cpu_write_norvalid got %b exp 0", cpu_rvalid);
        end
        n_tests++;
        if ({cpu_ready, mem_we} !== 2'b10) begin
            n_fail++;
            $display("FAIL cpu_read_accept got %b exp 10", {cpu_ready, mem_we});
        end
        @(negedge clk);
        cpu_valid = 1'b0;
        #1;
        n_tests++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 24'hABCDEF) begin
            n_fail++;
            $display("FAIL cpu_read_data got rv=%b d=%h exp 1 abcdef", cpu_rvalid, cpu_rdata);
        end
    endtask

    task automatic test_collision();
        @(negedge clk);
        disp_req = 1'b1; disp_addr = 19'h00010;
        cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00020;
        #1;
        n_tests++;
        if ({disp_gnt, cpu_ready} !== 2'b10 || mem_addr !== 19'h00010) begin
            n_fail++;
            $display("FAIL collide_grant got g/r=%b addr=%h exp 10 00010",
                     {disp_gnt, cpu_ready}, mem_addr);
        end
        @(negedge clk);
        disp_req = 1'b0;
        #1;
        n_tests++;
        if (disp_rvalid !== 1'b1 || disp_rdata !== 24'hABCDEF) begin
            n_fail++;
            $display("FAIL collide_disp_rvalid got rv=%b d=%h exp 1 abcdef",
                     disp_rvalid, disp_rdata);
        end
        n_tests++;
        if ({cpu_ready, mem_addr} !== {1'b1, 19'h00020}) begin
            n_fail++;
            $display("FAIL collide_cpu_next got r=%b addr=%h exp 1 00020", cpu_ready, mem_addr);
        end
        @(negedge clk);
        cpu_valid = 1'b0;
    endtask

    task automatic test_starvation();
        @(negedge clk);
        disp_req = 1'b1; disp_addr = 19'h00011;
        cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00010;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 9) cpu_valid = 1'b0;
            #1;
            n_tests++;
            if (c < 8 && {disp_gnt, cpu_ready} !== 2'b10) begin
                n_fail++;
                $display("FAIL starve_deny c=%0d got %b exp 10", c, {disp_gnt, cpu_ready});
            end else if (c == 8 && {disp_gnt, cpu_ready, mem_addr} !== {2'b01, 19'h00010}) begin
                n_fail++;
                $display("FAIL starve_boost got g/r=%b addr=%h exp 01 00010",
                         {disp_gnt, cpu_ready}, mem_addr);
            end else if (c == 9 && {disp_gnt, disp_miss_cnt, cpu_rvalid, disp_rvalid}
                         !== {1'b1, 16'd1, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL starve_resume got g=%b miss=%0d crv=%b drv=%b exp 1 1 1 0",
                         disp_gnt, disp_miss_cnt, cpu_rvalid, disp_rvalid);
            end
        end
        @(negedge clk);
        disp_req = 1'b0;
    endtask

    task automatic test_reset_boost();
        @(negedge clk);
        disp_req = 1'b1; cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00010;
        repeat (8) @(negedge clk);
        #1;
        n_tests++;
        if (cpu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstboost_in_boost got %b exp 1", cpu_ready);
        end
        #1 clrn = 1'b0;
        @(negedge clk);
        #1;
        n_tests++;
        if ({cpu_rvalid, disp_rvalid, disp_miss_cnt} !== {2'b00, 16'd0}) begin
            n_fail++;
            $display("FAIL rstboost_flush got rv=%b miss=%0d exp 00 0",
                     {cpu_rvalid, disp_rvalid}, disp_miss_cnt);
        end
        clrn = 1'b1;
        // wait_cnt must restart at 0: eight more denials before the forced slot
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            n_tests++;
            if (cpu_ready !== (i == 8) || disp_gnt !== (i != 8)) begin
                n_fail++;
                $display("FAIL rstboost_after i=%0d got g/r=%b%b exp %b%b",
                         i, disp_gnt, cpu_ready, i != 8, i == 8);
            end
        end
        @(negedge clk);
        disp_req = 1'b0; cpu_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_saturate();
        @(negedge clk);
        s_req = 1'b1; s_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (k > 0) begin
                n_tests++;
                if (s_cnt !== 2'((k > 3) ? 3 : k)) begin
                    n_fail++;
                    $display("FAIL sat_cnt k=%0d got %0d exp %0d", k, s_cnt, (k > 3) ? 3 : k);
                end
            end
            n_tests++;
            if ({s_gnt, s_ready} !== 2'b10) begin
                n_fail++;
                $display("FAIL sat_normal k=%0d got %b exp 10", k, {s_gnt, s_ready});
            end
            @(negedge clk);
            #1;
            n_tests++;
            if ({s_gnt, s_ready} !== 2'b01) begin
                n_fail++;
                $display("FAIL sat_boost k=%0d got %b exp 01", k, {s_gnt, s_ready});
            end
        end
        @(negedge clk);
        s_req = 1'b0; s_valid = 1'b0;
        #1;
        n_tests++;
        if (s_cnt !== 2'd3) begin
            n_fail++;
            $display("FAIL sat_final got %0d exp 3", s_cnt);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 24'h000000;
        test_reset();
        test_cpu_only();
        test_collision();
        test_starvation();
        test_reset_boost();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
